// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and frame constants.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit with a configurable reset level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; only sync_q is safe to use in the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronised rx, half-bit start check, mid-bit data
// sampling, stop-bit validation and a 1-entry valid/ready output register.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      busy_o,
  output logic                      frame_err_o,
  output logic                      overrun_o
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  uart_state_e               state_q;
  logic [CW-1:0]             cnt_q;
  logic [2:0]                idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      valid_q;
  logic                      frame_err_q;
  logic                      overrun_q;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rx_s)
  );

  // Frame FSM plus holding register; error flags are one-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // A pop frees the slot; a completion later in this block may refill it.
      if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end

        START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            idx_q <= '0;
            // Line back high at mid start bit means it was a glitch.
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            // LSB arrives first, so shift right from the top.
            shift_q <= {rx_s, shift_q[UART_DATA_BITS-1:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == IDX_LAST) begin
              state_q <= STOP;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q <= '0;
            if (rx_s) begin
              if (!valid_q || ready_i) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        BREAK: begin
          // Hold here so a line stuck low reports only one framing error.
          if (rx_s) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign busy_o      = (state_q != IDLE);
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

endmodule : uart_rx_8n1

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1 at CLKS_PER_BIT=4.
module tb_uart_rx_8n1;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready_i = 1'b0;
  logic [7:0] data_o;
  logic       valid_o;
  logic       busy_o;
  logic       frame_err_o;
  logic       overrun_o;

  int total = 0;
  int bad = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;

  uart_rx_8n1 #(
    .CLKS_PER_BIT(C)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  // Running totals of error pulses over the whole run.
  always @(posedge clk) begin
    if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
    if (overrun_o)   ovr_cnt  <= ovr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Call at a negedge. Returns at the negedge just before the clk edge that
  // samples the stop bit (the 41st edge counting the one that first saw rx=0).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop_bit;
    repeat (C) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data_o), 32'h00);
    check("rst_valid", 32'(valid_o), 32'h0);
    check("rst_busy", 32'(busy_o), 32'h0);
    check("rst_ferr", 32'(frame_err_o), 32'h0);
    check("rst_ovr", 32'(overrun_o), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 0xA5 with ready held high: valid_o high for exactly one cycle at latency 41
    ready_i = 1'b1;
    send_frame(8'hA5, 1'b1);
    check("a5_pre_valid", 32'(valid_o), 32'h0);
    @(posedge clk); #1;
    check("a5_valid", 32'(valid_o), 32'h1);
    check("a5_data", 32'(data_o), 32'hA5);
    @(posedge clk); #1;
    check("a5_popped", 32'(valid_o), 32'h0);

    // 0x3C with a low stop bit, then the line held low (break)
    @(negedge clk);
    send_frame(8'h3C, 1'b0);
    @(posedge clk); #1;
    check("3c_ferr", 32'(frame_err_o), 32'h1);
    check("3c_valid", 32'(valid_o), 32'h0);
    @(posedge clk); #1;
    check("3c_ferr_pulse", 32'(frame_err_o), 32'h0);
    repeat (10) @(negedge clk);
    check("brk_busy", 32'(busy_o), 32'h1);
    check("brk_ferr_cnt", 32'(ferr_cnt), 32'd1);
    check("brk_valid", 32'(valid_o), 32'h0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("brk_exit_busy", 32'(busy_o), 32'h0);
    send_frame(8'h55, 1'b1);
    @(posedge clk); #1;
    check("55_valid", 32'(valid_o), 32'h1);
    check("55_data", 32'(data_o), 32'h55);
    @(posedge clk); #1;
    check("55_popped", 32'(valid_o), 32'h0);

    // One-cycle low glitch: START entered then abandoned
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    @(negedge clk);
    check("gl_busy_e1", 32'(busy_o), 32'h0);
    @(negedge clk);
    check("gl_busy_e2", 32'(busy_o), 32'h1);
    repeat (2) @(negedge clk);
    check("gl_busy_e4", 32'(busy_o), 32'h0);
    repeat (4) @(negedge clk);
    check("gl_valid", 32'(valid_o), 32'h0);
    check("gl_ferr_cnt", 32'(ferr_cnt), 32'd1);

    // Overrun: 0x11 then 0x22 with nobody popping
    ready_i = 1'b0;
    send_frame(8'h11, 1'b1);
    @(posedge clk); #1;
    check("11_valid", 32'(valid_o), 32'h1);
    check("11_data", 32'(data_o), 32'h11);
    @(negedge clk);
    send_frame(8'h22, 1'b1);
    @(posedge clk); #1;
    check("22_overrun", 32'(overrun_o), 32'h1);
    check("22_keep_data", 32'(data_o), 32'h11);
    check("22_keep_valid", 32'(valid_o), 32'h1);
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk); #1;
    check("ovr_popped", 32'(valid_o), 32'h0);
    check("ovr_pulse", 32'(overrun_o), 32'h0);
    @(negedge clk);
    ready_i = 1'b0;

    // Back-to-back 0x00, 0xFF with the pop landing on the completion edge
    send_frame(8'h00, 1'b1);
    @(posedge clk); #1;
    check("00_valid", 32'(valid_o), 32'h1);
    check("00_data", 32'(data_o), 32'h00);
    @(negedge clk);
    send_frame(8'hFF, 1'b1);
    ready_i = 1'b1;
    @(posedge clk); #1;
    check("ff_valid", 32'(valid_o), 32'h1);
    check("ff_data", 32'(data_o), 32'hFF);
    check("ff_no_overrun", 32'(overrun_o), 32'h0);
    @(posedge clk); #1;
    check("ff_popped", 32'(valid_o), 32'h0);
    check("b2b_ovr_cnt", 32'(ovr_cnt), 32'd1);
    @(negedge clk);
    ready_i = 1'b0;

    // Reset in the middle of data bit 4 of 0xFF
    rx = 1'b0;
    repeat (C) @(negedge clk);
    rx = 1'b1;
    repeat (4 * C + 2) @(negedge clk);
    check("mid_busy", 32'(busy_o), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("mrst_busy", 32'(busy_o), 32'h0);
    check("mrst_valid", 32'(valid_o), 32'h0);
    check("mrst_data", 32'(data_o), 32'h00);
    check("mrst_ferr", 32'(frame_err_o), 32'h0);
    check("mrst_ovr", 32'(overrun_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post_rst_valid", 32'(valid_o), 32'h0);
    check("post_rst_busy", 32'(busy_o), 32'h0);
    ready_i = 1'b1;
    send_frame(8'h81, 1'b1);
    @(posedge clk); #1;
    check("81_valid", 32'(valid_o), 32'h1);
    check("81_data", 32'(data_o), 32'h81);
    repeat (3) @(negedge clk);
    check("end_ferr_cnt", 32'(ferr_cnt), 32'd1);
    check("end_ovr_cnt", 32'(ovr_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx_8n1
